// File: rtl/sipo_deserializer.sv
// Serial-in parallel-out word receiver with valid/ready output register.
// Define SIPO_PARITY_EN to take one extra even-parity bit after each word.
module sipo_deserializer #(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         serial_in,
    input  logic         shift_en,
    input  logic         clear,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    input  logic         data_ready,
    output logic         busy,
    output logic         overrun,
    output logic         parity_err
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sr_q, sr_d;
    logic [N-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;
    logic          busy_q, busy_d;
    logic [N-1:0]  sr_shift;
    logic [N-1:0]  word;
    logic          accept;
    logic          done;
`ifdef SIPO_PARITY_EN
    logic          perr_q, perr_d;
    logic          word_perr;
`endif

    always_comb begin
        if (MSB_FIRST) sr_shift = {sr_q[N-2:0], serial_in};
        else           sr_shift = {serial_in, sr_q[N-1:1]};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        done    = 1'b0;
        word    = sr_shift;
`ifdef SIPO_PARITY_EN
        perr_d    = perr_q;
        word_perr = 1'b0;
`endif
        accept = valid_q & data_ready;
        if (accept) valid_d = 1'b0;

        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            sr_d    = '0;
            ovr_d   = 1'b0;
        end else if (shift_en) begin
`ifdef SIPO_PARITY_EN
            if (state_q == PARITY) begin
                done      = 1'b1;
                word      = sr_q;
                word_perr = ^{sr_q, serial_in};
            end else if (cnt_q == LAST) begin
                sr_d    = sr_shift;
                cnt_d   = CW'(N);
                state_d = PARITY;
            end
`else
            if (cnt_q == LAST) begin
                done = 1'b1;
            end
`endif
            else begin
                sr_d    = sr_shift;
                cnt_d   = cnt_q + CW'(1);
                state_d = SHIFT;
            end

            // Output register is free if empty or being drained this edge
            if (done) begin
                state_d = IDLE;
                cnt_d   = '0;
                sr_d    = '0;
                if (!valid_q || accept) begin
                    data_d  = word;
                    valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
                    perr_d  = word_perr;
`endif
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) perr_q <= 1'b0;
        else          perr_q <= perr_d;
    end
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer: MSB-first and LSB-first instances in parallel,
// table-driven words checked through a scoreboard plus handshake corner cases.
module tb_sipo_deserializer;

`ifdef SIPO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       serial_in = 1'b0;
    logic       shift_en = 1'b0;
    logic       clear = 1'b0;
    logic       data_ready = 1'b0;
    logic [7:0] dout_m, dout_l;
    logic       valid_m, valid_l;
    logic       busy_m, busy_l;
    logic       ovr_m, ovr_l;
    logic       pe_m, pe_l;

    int total = 0;
    int bad = 0;
    bit sb_en = 1'b0;

    typedef struct {
        logic [7:0] m;
        logic [7:0] l;
        logic       pe;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [7:0] val;
        int         gap;
        logic [7:0] exp_m;
        logic [7:0] exp_l;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    sipo_deserializer #(.N(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset_n(reset_n), .serial_in(serial_in),
        .shift_en(shift_en), .clear(clear), .data_out(dout_m),
        .data_valid(valid_m), .data_ready(data_ready), .busy(busy_m),
        .overrun(ovr_m), .parity_err(pe_m)
    );

    sipo_deserializer #(.N(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset_n(reset_n), .serial_in(serial_in),
        .shift_en(shift_en), .clear(clear), .data_out(dout_l),
        .data_valid(valid_l), .data_ready(data_ready), .busy(busy_l),
        .overrun(ovr_l), .parity_err(pe_l)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_en && reset_n && valid_m && data_ready) begin
            chk("valid_pair", valid_l, 1'b1);
            if (sbq.size() == 0) begin
                chk("unexpected_word", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("word_msb", dout_m, e.m);
                chk("word_lsb", dout_l, e.l);
                chk("parity", pe_m, e.pe);
            end
        end
    end

    // Called at negedge+1; returns at the following negedge+1
    task automatic strobe(input logic b);
        shift_en  = 1'b1;
        serial_in = b;
        @(negedge clk);
        #1;
        shift_en  = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] val, input int gap,
                             input logic pbit, input bit push,
                             input logic [7:0] em, input logic [7:0] el,
                             input logic epe);
        exp_t e;
        e.m  = em;
        e.l  = el;
        e.pe = epe;
        for (int i = 0; i < 8; i++) begin
            if (push && i == 7 && !PAR) sbq.push_back(e);
            strobe(val[7-i]);
            chk("busy_bit", busy_m, (i < 7) || PAR);
            if (gap > 0) begin
                repeat (gap) @(negedge clk);
                #1;
            end
        end
        if (PAR) begin
            if (push) sbq.push_back(e);
            strobe(pbit);
            chk("busy_par", busy_m, 1'b0);
        end
    endtask

    initial begin
        logic [7:0] w;
        vecs[0] = '{8'hAA, 0, 8'hAA, 8'h55};
        vecs[1] = '{8'hAA, 3, 8'hAA, 8'h55};
        vecs[2] = '{8'h3C, 0, 8'h3C, 8'h3C};
        vecs[3] = '{8'h00, 0, 8'h00, 8'h00};
        vecs[4] = '{8'hFF, 1, 8'hFF, 8'hFF};
        vecs[5] = '{8'h81, 0, 8'h81, 8'h81};
        vecs[6] = '{8'h12, 2, 8'h12, 8'h48};

        #12;
        chk("rst_data", dout_m, 8'h00);
        chk("rst_valid", valid_m, 1'b0);
        chk("rst_busy", busy_m, 1'b0);
        chk("rst_ovr", ovr_m, 1'b0);
        chk("rst_perr", pe_m, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;

        sb_en = 1'b1;
        data_ready = 1'b1;
        foreach (vecs[k]) begin
            w = vecs[k].val;
            send_word(w, vecs[k].gap, ^w, 1'b1,
                      vecs[k].exp_m, vecs[k].exp_l, 1'b0);
        end
        @(negedge clk);
        chk("one_cycle_valid", valid_m, 1'b0);
        #1;

        // Backpressure and overrun
        sb_en = 1'b0;
        data_ready = 1'b0;
        send_word(8'h3C, 0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
        chk("bp_valid", valid_m, 1'b1);
        chk("bp_data1", dout_m, 8'h3C);
        chk("bp_ovr0", ovr_m, 1'b0);
        send_word(8'hC3, 0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
        chk("bp_data2", dout_m, 8'h3C);
        chk("bp_ovr1", ovr_m, 1'b1);
        chk("bp_ovr1_l", ovr_l, 1'b1);
        data_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain", valid_m, 1'b0);
        chk("bp_hold", dout_m, 8'h3C);
        #1;
        data_ready = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        chk("clr_ovr", ovr_m, 1'b0);
        chk("clr_keep", dout_m, 8'h3C);
        #1;
        clear = 1'b0;

        // Acceptance on the completion edge
        send_word(8'h11, 0, 1'b0, 1'b0, 8'h0, 8'h0, 1'b0);
        w = 8'h22;
        for (int i = 0; i < 7; i++) strobe(w[7-i]);
        if (PAR) strobe(w[0]);
        data_ready = 1'b1;
        if (PAR) strobe(1'b0);
        else     strobe(w[0]);
        chk("same_valid", valid_m, 1'b1);
        chk("same_data", dout_m, 8'h22);
        chk("same_ovr", ovr_m, 1'b0);
        @(negedge clk);
        chk("same_drain", valid_m, 1'b0);
        #1;
        sb_en = 1'b1;

        // Abort with clear on a strobe edge
        strobe(1'b1);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b1);
        chk("abort_busy1", busy_m, 1'b1);
        clear = 1'b1;
        strobe(1'b1);
        clear = 1'b0;
        chk("abort_busy0", busy_m, 1'b0);
        send_word(8'hF0, 0, 1'b0, 1'b1, 8'hF0, 8'h0F, 1'b0);

        // Asynchronous reset mid-word
        for (int i = 0; i < 5; i++) strobe(i[0]);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_data", dout_m, 8'h00);
        chk("arst_valid", valid_m, 1'b0);
        chk("arst_busy", busy_m, 1'b0);
        chk("arst_busy_l", busy_l, 1'b0);
        chk("arst_ovr", ovr_m, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        send_word(8'h5B, 0, 1'b1, 1'b1, 8'h5B, 8'hDA, 1'b0);

`ifdef SIPO_PARITY_EN
        send_word(8'hA5, 0, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0);
        send_word(8'hA5, 0, 1'b1, 1'b1, 8'hA5, 8'hA5, 1'b1);
`endif

        for (int t = 0; t < 40 && sbq.size() != 0; t++) @(negedge clk);
        chk("drain_queue", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in, parallel-out receiver that reassembles N-bit words from a one-bit-per-strobe serial stream, such as the stream produced by the PISO shift register. Each completed word is held in an output register behind a valid/ready handshake, so the next word can shift in while the current one waits. Bit order, overrun detection and an optional parity check are handled here, so downstream logic sees only whole words.

## Interface
- `N`, default 8: word width in data bits, ≥ 2.
- `MSB_FIRST`, default 1: 1 = first received bit lands in bit N-1; 0 = first received bit lands in bit 0.

- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `serial_in`  in  1: serial data bit, sampled only when `shift_en` = 1.
- `shift_en`  in  1: bit strobe; one bit is captured per rising edge where it is high.
- `clear`  in  1: synchronous abort of the partial word; also clears `overrun`.
- `data_out`  out  N: last completed word; stable while `data_valid` = 1.
- `data_valid`  out  1: word available.
- `data_ready`  in  1: consumer accepts the word when `data_valid` && `data_ready` at an edge.
- `busy`  out  1: partial word in progress (bit counter ≠ 0).
- `overrun`  out  1: sticky; a completed word was dropped.
- `parity_err`  out  1: parity result for the word in `data_out`.

## Operation
- Reset, asynchronous on `reset_n` = 0:
  - `data_out` = 0, `data_valid` = 0, `busy` = 0, `overrun` = 0, `parity_err` = 0.
  - Internal shift register and bit counter cleared; FSM enters IDLE.
- FSM states:
  - IDLE (count 0): the first `shift_en` moves the FSM to SHIFT, or completes the word directly when N = 1 is excluded by the parameter rule.
  - SHIFT (count 1..N-1).
  - PARITY: only when the macro is defined; waits for the parity bit.
- Bit capture:
  - Each edge with `shift_en` = 1 captures `serial_in` and increments the count.
  - MSB_FIRST = 1: shift left, inserting at bit 0. MSB_FIRST = 0: shift right, inserting at bit N-1.
- Word completion (Nth data bit, or the parity bit when enabled):
  - The count returns to 0 and the FSM returns to IDLE.
  - If the output register is free (`data_valid` = 0, or being accepted on this same edge), the assembled word is written to `data_out`, including the bit captured on this edge, and `data_valid` goes to 1.
  - Otherwise the new word is dropped, `data_out` is unchanged, and `overrun` is set to 1.
- Handshake:
  - Acceptance on an edge with no simultaneous completion: `data_valid` goes to 0 and `data_out` holds its last value.
  - Acceptance and completion on the same edge: `data_valid` stays 1, `data_out` takes the new word, and no overrun is flagged.
- `clear`:
  - Count goes to 0, shift register to 0, FSM to IDLE, `overrun` to 0.
  - `data_out`, `data_valid` and `parity_err` are untouched.
  - `clear` wins over a simultaneous `shift_en`; that bit is discarded.
  - A same-edge `data_ready` acceptance is still honoured.
- `shift_en` gaps of any length are legal and the partial word is retained.

## Timing
- Latency: `data_valid` rises in the cycle immediately after the edge that captured the last bit.
- Minimum word period: N edges, or N+1 with parity.
- Back-to-back words at full rate are lossless as long as `data_ready` is asserted at least once per word period.
- `busy` and `overrun` are registered outputs. `data_out` changes only on an edge that loads a word.

## Configuration
- `SIPO_PARITY_EN` defined:
  - After N data bits, one extra `shift_en` bit is taken as an even-parity bit (PARITY state).
  - `parity_err` = XOR of the N data bits and the parity bit, registered with `data_out`.
  - The parity bit is not stored in `data_out`.
  - Overrun and drop rules apply at parity-bit completion.
- `SIPO_PARITY_EN` not defined:
  - No PARITY state; words complete after N bits.
  - `parity_err` is tied to 0, and the port remains present.

## Test plan
- Reset, then 8 strobes of 1,0,1,0,1,0,1,0 with N=8, MSB_FIRST=1 and `data_ready` = 1 → `data_out` = 8'hAA with a one-cycle `data_valid`; `busy` is high during strobes 1–7.
- Same bits with MSB_FIRST=0 → `data_out` = 8'h55. Strobes with 3-cycle gaps between them → same result.
- Backpressure: `data_ready` = 0; send 8'h3C then 8'hC3 → `data_out` stays 8'h3C, `overrun` = 1. Raise `data_ready` → `data_valid` = 0. Pulse `clear` → `overrun` = 0.
- Acceptance on the completion edge: with 8'h11 pending, assert `data_ready` on the edge that completes 8'h22 → `data_valid` stays 1, `data_out` = 8'h22, `overrun` = 0.
- Abort: after 4 bits, assert `clear` together with `shift_en`, then send 8'hF0 → `data_out` = 8'hF0. A separate run with `reset_n` low after 5 bits → all outputs 0 and the next full word is correct.
- With `SIPO_PARITY_EN`: 8'hA5 followed by parity bit 0 → `parity_err` = 0; 8'hA5 followed by parity bit 1 → `parity_err` = 1 and `data_out` = 8'hA5.
